// File: rtl/snake_sequencer_if.sv
// rtl/snake_sequencer_if.sv - game-flow control and snake_field link bundle
// Purpose: groups the snake_sequencer request inputs, snake_field reports and
//   control/status outputs into one bundle.
// Ports (signals):
//   start_req, pause_req, dir_req_valid, dir_req[1:0]  game requests
//   ate_apple, collision                                reports from snake_field
//   field_start, step, snake_dir[1:0]                   commands to snake_field
//   state[1:0], score[SCORE_W-1:0], level[2:0]          game status
// Modports: master drives requests/reports, slave is the sequencer.
interface snake_sequencer_if #(
  parameter int unsigned SCORE_W = 8
) ();
  logic               start_req;
  logic               pause_req;
  logic               dir_req_valid;
  logic [1:0]         dir_req;
  logic               ate_apple;
  logic               collision;
  logic               field_start;
  logic               step;
  logic [1:0]         snake_dir;
  logic [1:0]         state;
  logic [SCORE_W-1:0] score;
  logic [2:0]         level;

  modport master (
    output start_req, pause_req, dir_req_valid, dir_req, ate_apple, collision,
    input  field_start, step, snake_dir, state, score, level
  );

  modport slave (
    input  start_req, pause_req, dir_req_valid, dir_req, ate_apple, collision,
    output field_start, step, snake_dir, state, score, level
  );
endinterface

// File: rtl/snake_sequencer.sv
// rtl/snake_sequencer.sv - snake game-flow controller (FSM, step timer, dir queue, score)
// Purpose: owns the IDLE/RUN/PAUSE/OVER flow, the level-dependent step timer,
//   a 2-entry queue of pending direction changes and the score/level counters.
// Ports:
//   clk    in  system clock
//   rst_n  in  asynchronous reset, active low
//   sq_io  slave modport of snake_sequencer_if (requests, field reports,
//          field_start/step/snake_dir commands, state/score/level status)
module snake_sequencer #(
  parameter int unsigned BASE_PERIOD      = 12000000,
  parameter int unsigned PERIOD_STEP      = 1500000,
  parameter int unsigned MIN_PERIOD       = 3000000,
  parameter int unsigned APPLES_PER_LEVEL = 4,
  parameter int unsigned MAX_LEVEL        = 6,
  parameter int unsigned SCORE_W          = 8
) (
  input logic            clk,
  input logic            rst_n,
  snake_sequencer_if.slave sq_io
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_OVER  = 2'd3
  } state_e;

  // The timer never exceeds BASE_PERIOD-1 (the longest period).
  localparam int unsigned TW = (BASE_PERIOD > 2) ? $clog2(BASE_PERIOD) : 1;
  localparam int unsigned AW = (APPLES_PER_LEVEL > 2) ? $clog2(APPLES_PER_LEVEL) : 1;

  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
  localparam logic [2:0]         LEVEL_MAX  = 3'(MAX_LEVEL);
  localparam logic [AW-1:0]      APPLE_LAST = AW'(APPLES_PER_LEVEL - 1);
  localparam logic [31:0]        BASE32     = 32'(BASE_PERIOD);
  localparam logic [31:0]        STEP32     = 32'(PERIOD_STEP);
  localparam logic [31:0]        MIN32      = 32'(MIN_PERIOD);
  localparam logic [31:0]        SPAN32     = BASE32 - MIN32;

  state_e             state_q, state_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic               step_q, step_d;
  logic               fstart_q, fstart_d;
  logic [1:0]         dir_q, dir_d;
  logic [1:0]         q0_q, q0_d;
  logic [1:0]         q1_q, q1_d;
  logic [1:0]         qcnt_q, qcnt_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [2:0]         level_q, level_d;
  logic [AW-1:0]      apples_q, apples_d;

  logic [31:0] reduction;
  logic [31:0] period;
  logic [31:0] timer_ext;
  logic        timer_hit;

  // Period is clamped by comparing the reduction against the usable span,
  // so the subtraction can never wrap below MIN_PERIOD.
  always_comb begin
    reduction = 32'(level_q) * STEP32;
    period    = (reduction >= SPAN32) ? MIN32 : (BASE32 - reduction);
    timer_ext = 32'(timer_q);
    timer_hit = (timer_ext >= (period - 32'd1));
  end

  // Queue view after a possible pop; pushes are judged against this view.
  logic [1:0] dir_mid, q0_mid, q1_mid, cnt_mid, ref_dir;

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    step_d   = 1'b0;
    fstart_d = 1'b0;
    dir_d    = dir_q;
    q0_d     = q0_q;
    q1_d     = q1_q;
    qcnt_d   = qcnt_q;
    score_d  = score_q;
    level_d  = level_q;
    apples_d = apples_q;
    dir_mid  = dir_q;
    q0_mid   = q0_q;
    q1_mid   = q1_q;
    cnt_mid  = qcnt_q;
    ref_dir  = dir_q;

    if (sq_io.start_req) begin
      state_d  = S_RUN;
      fstart_d = 1'b1;
      timer_d  = '0;
      dir_d    = 2'd1;
      qcnt_d   = 2'd0;
      score_d  = '0;
      level_d  = 3'd0;
      apples_d = '0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (sq_io.collision) begin
            state_d = S_OVER;
            timer_d = '0;
          end else begin
            if (sq_io.ate_apple) begin
              if (score_q != SCORE_MAX) score_d = score_q + 1'b1;
              // Sub-counter wraps even once the level has saturated.
              if (apples_q == APPLE_LAST) begin
                apples_d = '0;
                if (level_q < LEVEL_MAX) level_d = level_q + 3'd1;
              end else begin
                apples_d = apples_q + AW'(1);
              end
            end

            // The pause edge itself freezes the timer.
            if (sq_io.pause_req) begin
              state_d = S_PAUSE;
            end else if (timer_hit) begin
              timer_d = '0;
              step_d  = 1'b1;
              if (qcnt_q != 2'd0) begin
                dir_mid = q0_q;
                q0_mid  = q1_q;
                cnt_mid = qcnt_q - 2'd1;
              end
            end else begin
              timer_d = timer_q + TW'(1);
            end

            ref_dir = (cnt_mid == 2'd0) ? dir_mid :
                      (cnt_mid == 2'd1) ? q0_mid : q1_mid;
            if (sq_io.dir_req_valid && (cnt_mid != 2'd2) &&
                (sq_io.dir_req != ref_dir) && (sq_io.dir_req != (ref_dir ^ 2'b10))) begin
              if (cnt_mid == 2'd0) q0_mid = sq_io.dir_req;
              else                 q1_mid = sq_io.dir_req;
              cnt_mid = cnt_mid + 2'd1;
            end

            dir_d  = dir_mid;
            q0_d   = q0_mid;
            q1_d   = q1_mid;
            qcnt_d = cnt_mid;
          end
        end
        S_PAUSE: begin
          if (sq_io.pause_req) state_d = S_RUN;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      step_q   <= 1'b0;
      fstart_q <= 1'b0;
      dir_q    <= 2'd1;
      q0_q     <= 2'd0;
      q1_q     <= 2'd0;
      qcnt_q   <= 2'd0;
      score_q  <= '0;
      level_q  <= 3'd0;
      apples_q <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      step_q   <= step_d;
      fstart_q <= fstart_d;
      dir_q    <= dir_d;
      q0_q     <= q0_d;
      q1_q     <= q1_d;
      qcnt_q   <= qcnt_d;
      score_q  <= score_d;
      level_q  <= level_d;
      apples_q <= apples_d;
    end
  end

  assign sq_io.field_start = fstart_q;
  assign sq_io.step        = step_q;
  assign sq_io.snake_dir   = dir_q;
  assign sq_io.state       = state_q;
  assign sq_io.score       = score_q;
  assign sq_io.level       = level_q;

endmodule

// File: tb/tb_snake_sequencer.sv
// tb/tb_snake_sequencer.sv - scoreboard bench for snake_sequencer
module tb_snake_sequencer;
  localparam int BASE  = 20;
  localparam int PSTEP = 4;
  localparam int MINP  = 8;
  localparam int APL   = 2;
  localparam int MAXL  = 6;
  localparam int SW    = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  snake_sequencer_if #(.SCORE_W(SW)) sq ();

  snake_sequencer #(
    .BASE_PERIOD(BASE), .PERIOD_STEP(PSTEP), .MIN_PERIOD(MINP),
    .APPLES_PER_LEVEL(APL), .MAX_LEVEL(MAXL), .SCORE_W(SW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sq_io(sq)
  );

  typedef struct {
    int cyc;
    bit fs;
    bit st;
    int dir;
    int score;
    int level;
    int state;
  } ev_t;

  ev_t sb[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc_n  = 0;

  int m_state, m_timer, m_dir, m_score, m_level, m_apples;
  int m_q[$];

  initial forever begin
    @(posedge clk);
    cyc_n++;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc_n);
    end
  endtask

  function automatic int period_of(input int lvl);
    int p;
    p = BASE - lvl * PSTEP;
    return (p < MINP) ? MINP : p;
  endfunction

  task automatic model_reset();
    m_state = 0; m_timer = 0; m_dir = 1;
    m_score = 0; m_level = 0; m_apples = 0;
    m_q.delete();
  endtask

  task automatic model_cycle(input bit st, input bit pa, input bit dv, input int d,
                             input bit ate, input bit col);
    bit   fs;
    bit   stp;
    int   per;
    int   rf;
    ev_t  e;
    fs = 0; stp = 0;
    if (st) begin
      m_state = 1; fs = 1; m_timer = 0; m_dir = 1;
      m_score = 0; m_level = 0; m_apples = 0; m_q.delete();
    end else if (m_state == 1) begin
      if (col) begin
        m_state = 3; m_timer = 0;
      end else begin
        per = period_of(m_level);
        if (ate) begin
          if (m_score < (1 << SW) - 1) m_score++;
          m_apples++;
          if (m_apples == APL) begin
            m_apples = 0;
            if (m_level < MAXL) m_level++;
          end
        end
        if (pa) m_state = 2;
        else if (m_timer >= per - 1) begin
          stp = 1; m_timer = 0;
          if (m_q.size() > 0) m_dir = m_q.pop_front();
        end else m_timer++;
        if (dv) begin
          rf = (m_q.size() > 0) ? m_q[$] : m_dir;
          if (m_q.size() < 2 && d != rf && d != (rf ^ 2)) m_q.push_back(d);
        end
      end
    end else if (m_state == 2 && pa) begin
      m_state = 1;
    end
    if (fs || stp) begin
      e.cyc = cyc_n + 1; e.fs = fs; e.st = stp; e.dir = m_dir;
      e.score = m_score; e.level = m_level; e.state = m_state;
      sb.push_back(e);
    end
  endtask

  task automatic cyc(input bit st, input bit pa, input bit dv, input int d,
                     input bit ate, input bit col);
    sq.start_req     = st;
    sq.pause_req     = pa;
    sq.dir_req_valid = dv;
    sq.dir_req       = 2'(d);
    sq.ate_apple     = ate;
    sq.collision     = col;
    model_cycle(st, pa, dv, d, ate, col);
    @(posedge clk);
    #1;
  endtask

  task automatic idle1();            cyc(0, 0, 0, 0, 0, 0); endtask
  task automatic idle(input int n);  repeat (n) idle1();    endtask
  task automatic start();            cyc(1, 0, 0, 0, 0, 0); endtask
  task automatic pause();            cyc(0, 1, 0, 0, 0, 0); endtask
  task automatic dir(input int d);   cyc(0, 0, 1, d, 0, 0); endtask
  task automatic apple();            cyc(0, 0, 0, 0, 1, 0); endtask

  task automatic wait_step(input string nm, input int maxc, output int n);
    n = 0;
    do begin
      idle1();
      n++;
    end while (!sq.step && n < maxc);
    if (!sq.step) begin
      checks++;
      errors++;
      $display("FAIL %s: no step within %0d cycles", nm, maxc);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_state"},       int'(sq.state), 0);
    chk({tag, "_step"},        int'(sq.step), 0);
    chk({tag, "_field_start"}, int'(sq.field_start), 0);
    chk({tag, "_dir"},         int'(sq.snake_dir), 1);
    chk({tag, "_score"},       int'(sq.score), 0);
    chk({tag, "_level"},       int'(sq.level), 0);
  endtask

  // Monitor: every step/field_start pulse is matched to the oldest prediction.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        while (sb.size() > 0 && sb[0].cyc < cyc_n) begin
          e = sb.pop_front();
          checks++;
          errors++;
          $display("FAIL missed_event: expected pulse at cycle %0d, none by cycle %0d", e.cyc, cyc_n);
        end
        if (sq.step || sq.field_start) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: step=%0d field_start=%0d at cycle %0d, expected none",
                     sq.step, sq.field_start, cyc_n);
          end else begin
            e = sb.pop_front();
            chk("ev_cycle",       cyc_n, e.cyc);
            chk("ev_field_start", int'(sq.field_start), int'(e.fs));
            chk("ev_step",        int'(sq.step), int'(e.st));
            chk("ev_dir",         int'(sq.snake_dir), e.dir);
            chk("ev_score",       int'(sq.score), e.score);
            chk("ev_level",       int'(sq.level), e.level);
            chk("ev_state",       int'(sq.state), e.state);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int steps;
    rst_n = 1'b0;
    sq.start_req = 0; sq.pause_req = 0; sq.dir_req_valid = 0;
    sq.dir_req = 0; sq.ate_apple = 0; sq.collision = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    // Start and first step timing.
    start();
    chk("start_field_start", int'(sq.field_start), 1);
    chk("start_state", int'(sq.state), 1);
    wait_step("first_step", 40, n);
    chk("first_step_delay", n, 20);
    wait_step("second_step", 40, n);
    chk("second_step_delay", n, 20);

    // Direction queue: reverse dropped, two queued, third dropped.
    dir(3);
    dir(0);
    dir(3);
    dir(2);
    wait_step("dir_step1", 40, n);
    chk("dir_first_pop", int'(sq.snake_dir), 0);
    wait_step("dir_step2", 40, n);
    chk("dir_second_pop", int'(sq.snake_dir), 3);
    wait_step("dir_step3", 40, n);
    chk("dir_third_dropped", int'(sq.snake_dir), 3);

    // Pause with timer at 7, hold 100 cycles, resume.
    idle(7);
    pause();
    chk("pause_state", int'(sq.state), 2);
    steps = 0;
    repeat (100) begin
      idle1();
      if (sq.step) steps++;
    end
    chk("pause_no_step", steps, 0);
    pause();
    chk("resume_state", int'(sq.state), 1);
    wait_step("resume_step", 40, n);
    chk("resume_step_delay", n, 13);

    // Apples: levels, period shrink and clamp, score saturation.
    apple();
    idle1();
    apple();
    chk("score_2", int'(sq.score), 2);
    chk("level_1", int'(sq.level), 1);
    wait_step("lvl1_sync", 40, n);
    wait_step("lvl1_period", 40, n);
    chk("level1_period", n, 16);
    repeat (10) apple();
    chk("score_12", int'(sq.score), 12);
    chk("level_6", int'(sq.level), 6);
    wait_step("lvl6_sync", 40, n);
    wait_step("lvl6_period", 40, n);
    chk("level6_period_clamped", n, 8);
    repeat (5) apple();
    chk("score_saturated", int'(sq.score), 15);
    chk("level_saturated", int'(sq.level), 6);

    // collision + ate_apple + pause in one cycle.
    cyc(0, 1, 0, 0, 1, 1);
    chk("over_state", int'(sq.state), 3);
    chk("over_score_held", int'(sq.score), 15);
    chk("over_level_held", int'(sq.level), 6);
    steps = 0;
    repeat (50) begin
      idle1();
      if (sq.step) steps++;
    end
    chk("over_no_step", steps, 0);
    start();
    chk("restart_state", int'(sq.state), 1);
    chk("restart_score", int'(sq.score), 0);
    chk("restart_level", int'(sq.level), 0);
    chk("restart_dir", int'(sq.snake_dir), 1);
    chk("restart_field_start", int'(sq.field_start), 1);

    // Asynchronous reset with a full queue.
    idle(3);
    dir(0);
    dir(3);
    sq.dir_req_valid = 0;
    #2;
    rst_n = 1'b0;
    sb.delete();
    model_reset();
    #1;
    chk_reset_outputs("async_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    start();
    dir(0);
    wait_step("post_reset_step1", 40, n);
    chk("post_reset_dir1", int'(sq.snake_dir), 0);
    wait_step("post_reset_step2", 40, n);
    chk("post_reset_dir2", int'(sq.snake_dir), 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 299) == 0,
          $urandom_range(0, 79) == 0,
          $urandom_range(0, 3) == 0,
          int'($urandom_range(0, 3)),
          $urandom_range(0, 11) == 0,
          $urandom_range(0, 199) == 0);
    end
    idle(2);
    @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
